stopwatch_lap: RTL

Parametrised successor to the single-channel BCD stopwatch: a 7-digit BCD timer (mm:ss.mmm) with a programmable millisecond prescaler, an optional count-down mode with preload and expiry, and a lap FIFO of configurable depth capturing timestamps on a button edge. It sits between debounced front-panel buttons, the 7-segment display driver and the CPU. The CPU sees it as a 4-word Avalon-MM slave with a level interrupt.

---
 rtl/stopwatch_lap.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_lap.sv
// stopwatch_lap: 7-digit BCD stopwatch (mm:ss.mmm) with a millisecond prescaler,
// split/hold display, a lap-timestamp FIFO and a 4-word Avalon-MM slave with a
// level interrupt.
// Optional feature macro: STOPWATCH_LAP_DOWN_EN enables count-down mode with a
// preload register (PRE) and an expiry flag (EXP). Without it the block is an
// up-counting stopwatch only.
module stopwatch_lap #(
  parameter int MSPN = 5,
  parameter int MSPL = $clog2(MSPN),
  parameter int LAPN = 4,
  parameter int LAPL = $clog2(LAPN),
  parameter int AAW  = 2,
  parameter int ADW  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           b_run,
  input  logic           b_clr,
  input  logic           b_lap,
  output logic [27:0]    t_bcd,
  output logic           s_run,
  output logic           s_hld,
  output logic           s_dn,
  input  logic [AAW-1:0] avalon_address,
  input  logic           avalon_write,
  input  logic           avalon_read,
  input  logic [ADW-1:0] avalon_writedata,
  output logic [ADW-1:0] avalon_readdata,
  output logic           avalon_interrupt
);

`ifdef STOPWATCH_LAP_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  // Per-digit rollover value, least significant digit first: ms,ms,ms,s,10s,min,10min
  function automatic logic [3:0] dig_max(input int i);
    return (i == 4 || i == 6) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [27:0] bcd_inc(input logic [27:0] v);
    logic [27:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (c) begin
        if (v[4*i +: 4] == dig_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [27:0] bcd_dec(input logic [27:0] v);
    logic [27:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = dig_max(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic            run_d_q, clr_d_q, lap_d_q;
  logic            run_e_q, clr_e_q, lap_e_q;
  logic            run_e_d, clr_e_d, lap_e_d;
  logic            s_run_q, s_run_d, s_hld_q, s_hld_d, s_dn_q, s_dn_d;
  logic            ie_q, ie_d, ovf_q, ovf_d, exp_q, exp_d;
  logic [MSPL-1:0] ps_q, ps_d;
  logic [27:0]     cnt_q, cnt_d, hold_q, hold_d, pre_q, pre_d;
  logic [27:0]     fifo_q [LAPN];
  logic [27:0]     fifo_d [LAPN];
  logic [LAPL:0]   wp_q, wp_d, rp_q, rp_d;

  logic            wr_ctrl, wr_time, wr_irq, rd_lap;
  logic [LAPL:0]   lap_cnt;
  logic            empty, full, tick, cnt_zero, push, pop, clr_ev, dn_wr;
  logic [31:0]     rd_word;
  logic            unused_wd;

  assign wr_ctrl  = avalon_write && (avalon_address == AAW'(0));
  assign wr_time  = avalon_write && (avalon_address == AAW'(1));
  assign wr_irq   = avalon_write && (avalon_address == AAW'(3));
  assign rd_lap   = avalon_read  && (avalon_address == AAW'(2));
  assign lap_cnt  = wp_q - rp_q;
  assign empty    = (lap_cnt == '0);
  assign full     = (lap_cnt == (LAPL+1)'(LAPN));
  assign tick     = s_run_q && (ps_q == MSPL'(MSPN - 1));
  assign cnt_zero = (cnt_q == 28'd0);
  assign push     = lap_e_q && s_run_q;
  assign pop      = rd_lap && !empty;
  assign clr_ev   = clr_e_q || (wr_ctrl && avalon_writedata[2]);
  assign dn_wr    = DOWN_EN && avalon_writedata[1];
  assign unused_wd = ^avalon_writedata;

  // Rising-edge detection of the debounced buttons; edges are registered once more
  always_comb begin
    run_e_d = b_run & ~run_d_q;
    clr_e_d = b_clr & ~clr_d_q;
    lap_e_d = b_lap & ~lap_d_q;
  end

  // Millisecond prescaler: held at zero while stopped, wraps on the tick
  always_comb begin
    ps_d = (!s_run_q || tick) ? '0 : ps_q + MSPL'(1);
  end

  // Run/hold/mode control, time counter, preload and sticky flags
  always_comb begin
    s_run_d = s_run_q;
    s_hld_d = s_hld_q;
    s_dn_d  = s_dn_q;
    ie_d    = ie_q;
    ovf_d   = ovf_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    pre_d   = pre_q;

    // A stopped down-counter sitting at zero cannot be started
    if (run_e_q) begin
      if (s_run_q)                     s_run_d = 1'b0;
      else if (!(s_dn_q && cnt_zero))  s_run_d = 1'b1;
    end

    // Register write overrides a same-cycle button edge
    if (wr_ctrl) begin
      ie_d = avalon_writedata[3];
      if (!s_run_q) s_dn_d = dn_wr;
      s_run_d = avalon_writedata[0] && (s_run_q || !(s_dn_d && cnt_zero));
    end

    if (clr_ev) begin
      if (s_run_q) begin
        s_hld_d = !s_hld_q;
        if (!s_hld_q) hold_d = cnt_q;
      end else if (s_hld_q) begin
        s_hld_d = 1'b0;
      end else begin
        cnt_d = s_dn_q ? pre_q : 28'd0;
      end
    end

    if (wr_time && !s_run_q && DOWN_EN) pre_d = avalon_writedata[27:0];

    // Flag clears first so a same-cycle set is not lost
    if (wr_irq) begin
      if (avalon_writedata[1]) ovf_d = 1'b0;
      if (avalon_writedata[2]) exp_d = 1'b0;
    end

    if (tick) begin
      if (s_dn_q) begin
        cnt_d = bcd_dec(cnt_q);
        if (cnt_q == 28'd1) begin
          s_run_d = 1'b0;
          exp_d   = 1'b1;
        end
      end else begin
        cnt_d = bcd_inc(cnt_q);
      end
    end

    if (push && full && !pop) ovf_d = 1'b1;
  end

  // Lap FIFO: push captures the pre-tick counter; push into a full FIFO only with a pop
  always_comb begin
    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (push && (!full || pop)) begin
      fifo_d[wp_q[LAPL-1:0]] = cnt_q;
      wp_d = wp_q + (LAPL+1)'(1);
    end
    if (pop) rp_d = rp_q + (LAPL+1)'(1);
  end

  // Combinational read mux, zero wait states
  always_comb begin
    rd_word = 32'd0;
    case (avalon_address)
      AAW'(0): rd_word = {16'd0, 8'(lap_cnt), 1'b0, full, empty, s_hld_q, ie_q,
                          1'b0, s_dn_q, s_run_q};
      AAW'(1): rd_word = {4'd0, cnt_q};
      AAW'(2): rd_word = empty ? 32'd0 : {1'b1, 3'd0, fifo_q[rp_q[LAPL-1:0]]};
      AAW'(3): rd_word = {29'd0, exp_q, ovf_q, !empty};
      default: rd_word = 32'd0;
    endcase
  end

  // State registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_d_q <= 1'b0;
      clr_d_q <= 1'b0;
      lap_d_q <= 1'b0;
      run_e_q <= 1'b0;
      clr_e_q <= 1'b0;
      lap_e_q <= 1'b0;
      s_run_q <= 1'b0;
      s_hld_q <= 1'b0;
      s_dn_q  <= 1'b0;
      ie_q    <= 1'b0;
      ovf_q   <= 1'b0;
      exp_q   <= 1'b0;
      ps_q    <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      pre_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      for (int i = 0; i < LAPN; i++) fifo_q[i] <= '0;
    end else begin
      run_d_q <= b_run;
      clr_d_q <= b_clr;
      lap_d_q <= b_lap;
      run_e_q <= run_e_d;
      clr_e_q <= clr_e_d;
      lap_e_q <= lap_e_d;
      s_run_q <= s_run_d;
      s_hld_q <= s_hld_d;
      s_dn_q  <= s_dn_d;
      ie_q    <= ie_d;
      ovf_q   <= ovf_d;
      exp_q   <= exp_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      fifo_q  <= fifo_d;
    end
  end

  assign t_bcd            = s_hld_q ? hold_q : cnt_q;
  assign s_run            = s_run_q;
  assign s_hld            = s_hld_q;
  assign s_dn             = s_dn_q;
  assign avalon_readdata  = ADW'(rd_word);
  assign avalon_interrupt = ie_q & (!empty | ovf_q | exp_q);

endmodule
